axi_hsuart_reg_arbiter: RTL and testbench

- Shares the single AXI4-Lite slave register port of axi_hsuart (4 x 32-bit registers at offsets 0x0/0x4/0x8/0xC) between two on-chip requesters, e.g. a boot-time config sequencer and a runtime status poller.
- Each requester issues single-register read/write commands over a valid/ready interface.
- The block arbitrates round-robin, runs one AXI4-Lite transaction at a time as master, and returns a tagged response.
- It sits between the requesters and the axi_hsuart S00_AXI port.

---
 rtl/axi_hsuart_pkg.sv | 24 ++
 rtl/axi_hsuart_reg_arbiter_if.sv | 43 ++++
 rtl/rr_arb2.sv | 32 +++
 rtl/axi_hsuart_reg_arbiter.sv | 158 +++++++++++++++
 tb/tb_axi_hsuart_reg_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_hsuart_pkg.sv
// Shared types and constants for the axi_hsuart register-port arbiter.
package axi_hsuart_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } arb_state_t;

  localparam int         HSUART_NUM_REGS = 4;
  localparam int         HSUART_DATA_W   = 32;
  localparam logic [2:0] PROT_DEFAULT    = 3'b000;

endpackage

// File: rtl/axi_hsuart_reg_arbiter_if.sv
// AXI4-Lite register bus between the arbiter (master) and axi_hsuart S00_AXI (slave).
interface axi_hsuart_reg_arbiter_if #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
);

  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                AWPROT;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                ARPROT;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer moves only on an enabled grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // 1 when requester 1 was granted most recently; reset favours requester 0
  logic last;

  // One-hot grant: a lone request wins, a tie goes to the side not granted last
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  // Remember who was granted so the next tie alternates
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (en && (|req))
      last <= grant[1];
  end

endmodule

// File: rtl/axi_hsuart_reg_arbiter.sv
// Shares the axi_hsuart AXI4-Lite register port between two requesters,
// one transaction at a time, with locally checked address errors.
module axi_hsuart_reg_arbiter
  import axi_hsuart_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = HSUART_DATA_W,
  parameter int C_NUM_REGS   = HSUART_NUM_REGS
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      rq0_valid,
  output logic                      rq0_ready,
  input  logic                      rq0_write,
  input  logic [C_ADDR_WIDTH-1:0]   rq0_addr,
  input  logic [C_DATA_WIDTH-1:0]   rq0_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] rq0_wstrb,
  input  logic                      rq1_valid,
  output logic                      rq1_ready,
  input  logic                      rq1_write,
  input  logic [C_ADDR_WIDTH-1:0]   rq1_addr,
  input  logic [C_DATA_WIDTH-1:0]   rq1_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] rq1_wstrb,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  axi_hsuart_reg_arbiter_if.master  M_AXI
);

  arb_state_t state, state_nx;

  logic [1:0]                grant;
  logic                      accept;
  logic                      sel_write;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_DATA_WIDTH-1:0]   sel_wdata;
  logic [C_DATA_WIDTH/8-1:0] sel_wstrb;
  logic                      sel_misalign;
  logic                      sel_oob;

  logic                      cmd_id;
  logic [C_ADDR_WIDTH-1:0]   cmd_addr;
  logic [C_DATA_WIDTH-1:0]   cmd_wdata;
  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb;
  logic                      aw_done;
  logic                      w_done;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_q;
  resp_t                     rsp_resp_q;

  logic aw_valid, w_valid, aw_hs, w_hs;

  rr_arb2 u_arb (
    .clk   (ACLK),
    .rst   (ARESET),
    .req   ({rq1_valid, rq0_valid}),
    .en    (state == IDLE),
    .grant (grant)
  );

  assign accept    = (state == IDLE) && (|grant) && !ARESET;
  assign rq0_ready = accept && grant[0];
  assign rq1_ready = accept && grant[1];

  assign sel_write    = grant[1] ? rq1_write : rq0_write;
  assign sel_addr     = grant[1] ? rq1_addr  : rq0_addr;
  assign sel_wdata    = grant[1] ? rq1_wdata : rq0_wdata;
  assign sel_wstrb    = grant[1] ? rq1_wstrb : rq0_wstrb;
  assign sel_misalign = |sel_addr[1:0];
  // Compare in 32 bits so the register-space limit is representable for narrow addresses
  assign sel_oob      = 32'(sel_addr) >= 32'(4 * C_NUM_REGS);

  // Valids come from state and done flags only, never from the slave's ready
  assign aw_valid = (state == WR_AW_W) && !aw_done;
  assign w_valid  = (state == WR_AW_W) && !w_done;
  assign aw_hs    = aw_valid && M_AXI.AWREADY;
  assign w_hs     = w_valid && M_AXI.WREADY;

  assign M_AXI.AWADDR  = cmd_addr;
  assign M_AXI.AWPROT  = PROT_DEFAULT;
  assign M_AXI.AWVALID = aw_valid;
  assign M_AXI.WDATA   = cmd_wdata;
  assign M_AXI.WSTRB   = cmd_wstrb;
  assign M_AXI.WVALID  = w_valid;
  assign M_AXI.BREADY  = (state == WR_B);
  assign M_AXI.ARADDR  = cmd_addr;
  assign M_AXI.ARPROT  = PROT_DEFAULT;
  assign M_AXI.ARVALID = (state == RD_AR);
  assign M_AXI.RREADY  = (state == RD_R);

  assign rsp_valid = (state == RESP);
  assign rsp_id    = cmd_id;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  // State register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state: local errors bypass the bus, otherwise walk the AXI channels
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_misalign || sel_oob) state_nx = RESP;
          else if (sel_write)          state_nx = WR_AW_W;
          else                         state_nx = RD_AR;
        end
      end
      WR_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_B;
      WR_B:    if (M_AXI.BVALID)  state_nx = RESP;
      RD_AR:   if (M_AXI.ARREADY) state_nx = RD_R;
      RD_R:    if (M_AXI.RVALID)  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command capture, per-channel handshake tracking and response capture
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_id      <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_wstrb   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      if (accept) begin
        cmd_id      <= grant[1];
        cmd_addr    <= sel_addr;
        cmd_wdata   <= sel_wdata;
        cmd_wstrb   <= sel_wstrb;
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= sel_misalign ? RESP_SLVERR :
                       sel_oob      ? RESP_DECERR : RESP_OKAY;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == WR_B) && M_AXI.BVALID)
        rsp_resp_q <= resp_t'(M_AXI.BRESP);
      if ((state == RD_R) && M_AXI.RVALID) begin
        rsp_rdata_q <= M_AXI.RDATA;
        rsp_resp_q  <= resp_t'(M_AXI.RRESP);
      end
    end
  end

endmodule

// File: tb/tb_axi_hsuart_reg_arbiter.sv
// Directed bench for axi_hsuart_reg_arbiter with a small AXI4-Lite register slave.
module tb_axi_hsuart_reg_arbiter;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rq0_valid = 1'b0, rq0_write = 1'b0;
  logic [AW-1:0] rq0_addr  = '0;
  logic [31:0]   rq0_wdata = '0;
  logic [3:0]    rq0_wstrb = '0;
  logic          rq1_valid = 1'b0, rq1_write = 1'b0;
  logic [AW-1:0] rq1_addr  = '0;
  logic [31:0]   rq1_wdata = '0;
  logic [3:0]    rq1_wstrb = '0;
  logic          rq0_ready, rq1_ready, rsp_valid, rsp_id;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;

  axi_hsuart_reg_arbiter_if #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32)) bus ();

  axi_hsuart_reg_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32), .C_NUM_REGS(4)) dut (
    .ACLK(clk), .ARESET(rst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata), .rq0_wstrb(rq0_wstrb),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata), .rq1_wstrb(rq1_wstrb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor (samples mid-cycle) ----------------
  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          at;
  } rsp_t;
  rsp_t rsp_q[$];

  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, awv_cyc = 0, wv_cyc = 0;
  int aw_at = -1, w_at = -1;
  logic [AW-1:0] aw_addr_seen = '0;
  logic [31:0]   w_data_seen  = '0;

  always @(negedge clk) begin
    if (rsp_valid) rsp_q.push_back(rsp_t'{rsp_id, rsp_rdata, rsp_resp, cyc});
    if (bus.AWVALID) awv_cyc++;
    if (bus.WVALID)  wv_cyc++;
    if (bus.AWVALID && bus.AWREADY) begin aw_cnt++; aw_at = cyc; aw_addr_seen = bus.AWADDR; end
    if (bus.WVALID && bus.WREADY)   begin w_cnt++;  w_at = cyc;  w_data_seen = bus.WDATA; end
    if (bus.ARVALID && bus.ARREADY) ar_cnt++;
    if (bus.BVALID && bus.BREADY)   b_cnt++;
  end

  // ---------------- AXI4-Lite slave model ----------------
  int         w_delay_cfg = 0;
  logic [1:0] bresp_cfg   = 2'b00;
  bit         r_stall     = 1'b0;

  logic [31:0]   sregs [4];
  logic          s_aw_got, s_w_got, s_bvalid, s_rvalid, s_ar_pend;
  logic [AW-1:0] s_aw_a, s_ar_a;
  logic [31:0]   s_w_d, s_rdata;
  logic [3:0]    s_w_s;
  int            s_w_seen;

  assign bus.AWREADY = !s_aw_got && !s_bvalid;
  assign bus.WREADY  = !s_w_got && !s_bvalid && (s_w_seen >= w_delay_cfg);
  assign bus.BVALID  = s_bvalid;
  assign bus.BRESP   = s_bvalid ? bresp_cfg : 2'b00;
  assign bus.ARREADY = !s_ar_pend && !s_rvalid;
  assign bus.RVALID  = s_rvalid;
  assign bus.RDATA   = s_rdata;
  assign bus.RRESP   = 2'b00;

  always @(posedge clk or posedge rst) begin : slave
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
    logic          awh, wh;
    if (rst) begin
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bvalid <= 1'b0;
      s_rvalid <= 1'b0; s_ar_pend <= 1'b0; s_w_seen <= 0;
      s_aw_a <= '0; s_ar_a <= '0; s_w_d <= '0; s_w_s <= '0; s_rdata <= '0;
    end else begin
      awh = bus.AWVALID && bus.AWREADY;
      wh  = bus.WVALID && bus.WREADY;
      if (bus.WVALID && !bus.WREADY) s_w_seen <= s_w_seen + 1;
      if (awh) begin s_aw_got <= 1'b1; s_aw_a <= bus.AWADDR; end
      if (wh)  begin s_w_got <= 1'b1; s_w_d <= bus.WDATA; s_w_s <= bus.WSTRB; s_w_seen <= 0; end
      a = awh ? bus.AWADDR : s_aw_a;
      d = wh  ? bus.WDATA  : s_w_d;
      s = wh  ? bus.WSTRB  : s_w_s;
      if ((s_aw_got || awh) && (s_w_got || wh)) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) sregs[a[3:2]][8*b +: 8] <= d[8*b +: 8];
        s_bvalid <= 1'b1; s_aw_got <= 1'b0; s_w_got <= 1'b0;
      end
      if (s_bvalid && bus.BREADY) s_bvalid <= 1'b0;
      if (bus.ARVALID && bus.ARREADY) begin
        if (r_stall) begin s_ar_pend <= 1'b1; s_ar_a <= bus.ARADDR; end
        else begin s_rvalid <= 1'b1; s_rdata <= sregs[bus.ARADDR[3:2]]; end
      end else if (s_ar_pend && !r_stall) begin
        s_rvalid <= 1'b1; s_rdata <= sregs[s_ar_a[3:2]]; s_ar_pend <= 1'b0;
      end
      if (s_rvalid && bus.RREADY) s_rvalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit id, input bit wr, input logic [AW-1:0] addr,
                      input logic [31:0] d, output int acc);
    @(posedge clk); #1;
    if (id) begin rq1_write = wr; rq1_addr = addr; rq1_wdata = d; rq1_wstrb = 4'hF; rq1_valid = 1'b1; end
    else    begin rq0_write = wr; rq0_addr = addr; rq0_wdata = d; rq0_wstrb = 4'hF; rq0_valid = 1'b1; end
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? rq1_ready : rq0_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    if (id) rq1_valid = 1'b0; else rq0_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_rsp(input string tag, input bit id, input logic [31:0] rdata,
                            input logic [1:0] resp, input int at);
    rsp_t r;
    for (int i = 0; i < 40 && rsp_q.size() == 0; i++) @(posedge clk);
    if (rsp_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      r = rsp_q.pop_front();
      check({tag, "_id"},    32'(r.id), 32'(id));
      check({tag, "_rdata"}, r.rdata, rdata);
      check({tag, "_resp"},  32'(r.resp), 32'(resp));
      if (at >= 0) check({tag, "_cycle"}, r.at, at);
    end
  endtask

  task automatic dual_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           output int first, output int second);
    bit g0, g1;
    first = -1; second = -1;
    @(posedge clk); #1;
    rq0_write = 1'b0; rq0_addr = a0; rq0_valid = 1'b1;
    rq1_write = 1'b0; rq1_addr = a1; rq1_valid = 1'b1;
    for (int i = 0; i < 40 && (rq0_valid || rq1_valid); i++) begin
      @(negedge clk);
      g0 = rq0_ready; g1 = rq1_ready;
      if (g0 || g1) begin
        if (first < 0) first = g1 ? 1 : 0;
        else           second = g1 ? 1 : 0;
      end
      @(posedge clk); #1;
      if (g0) rq0_valid = 1'b0;
      if (g1) rq1_valid = 1'b0;
    end
    rq0_valid = 1'b0; rq1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int acc, first, second, ar0, aw0, awv0, wv0, b0;
    logic [AW-1:0] wa [3];
    logic [31:0]   wd [3];
    bit            wi [3];
    wa = '{5'h0, 5'h8, 5'hC}; wd = '{32'd1, 32'd3, 32'd4}; wi = '{1'b0, 1'b1, 1'b0};

    // Reset: everything low even with a request pending
    rq0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 32'({rq0_ready, rq1_ready, rsp_valid, bus.AWVALID, bus.WVALID,
                          bus.BREADY, bus.ARVALID, bus.RREADY}), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_id_resp", 32'({rsp_id, rsp_resp}), 32'd0);
    check("rst_addr", 32'(bus.AWADDR), 32'd0);
    rq0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait write: AW/W at T1, rsp at T3
    send(1'b0, 1'b1, 5'h4, 32'h2, acc);
    expect_rsp("wr1", 1'b0, 32'd0, 2'b00, acc + 3);
    check("wr1_aw_cycle", aw_at, acc + 1);
    check("wr1_w_cycle", w_at, acc + 1);
    check("wr1_awaddr", 32'(aw_addr_seen), 32'h4);
    check("wr1_wdata", w_data_seen, 32'h2);

    for (int i = 0; i < 3; i++) begin
      send(wi[i], 1'b1, wa[i], wd[i], acc);
      expect_rsp("wr_fill", wi[i], 32'd0, 2'b00, acc + 3);
    end

    // Reset pulse brings the pointer back to favour rq0
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    dual_read(5'h0, 5'h4, first, second);
    check("dual1_first", first, 0);
    check("dual1_second", second, 1);
    expect_rsp("dual1_a", 1'b0, 32'd1, 2'b00, -1);
    expect_rsp("dual1_b", 1'b1, 32'd2, 2'b00, -1);

    send(1'b0, 1'b0, 5'hC, 32'd0, acc);
    expect_rsp("rd_c", 1'b0, 32'd4, 2'b00, acc + 3);

    // Last grant was rq0, so a tie now goes to rq1
    dual_read(5'h8, 5'h8, first, second);
    check("dual2_first", first, 1);
    check("dual2_second", second, 0);
    expect_rsp("dual2_a", 1'b1, 32'd3, 2'b00, -1);
    expect_rsp("dual2_b", 1'b0, 32'd3, 2'b00, -1);

    // Local errors: no bus activity, rsp at T1, rdata zero
    ar0 = ar_cnt; aw0 = aw_cnt;
    send(1'b1, 1'b0, 5'h6, 32'd0, acc);
    expect_rsp("slverr_rd", 1'b1, 32'd0, 2'b10, acc + 1);
    send(1'b1, 1'b0, 5'h10, 32'd0, acc);
    expect_rsp("decerr_rd", 1'b1, 32'd0, 2'b11, acc + 1);
    send(1'b0, 1'b1, 5'h2, 32'hDEAD, acc);
    expect_rsp("slverr_wr", 1'b0, 32'd0, 2'b10, acc + 1);
    check("err_no_ar", ar_cnt - ar0, 0);
    check("err_no_aw", aw_cnt - aw0, 0);

    // WREADY held off 3 cycles past the AW handshake
    w_delay_cfg = 3; awv0 = awv_cyc; wv0 = wv_cyc; b0 = b_cnt;
    send(1'b0, 1'b1, 5'h8, 32'h33, acc);
    expect_rsp("wdly", 1'b0, 32'd0, 2'b00, acc + 6);
    w_delay_cfg = 0;
    check("wdly_aw_cycle", aw_at, acc + 1);
    check("wdly_w_cycle", w_at, acc + 4);
    check("wdly_awvalid_cycles", awv_cyc - awv0, 1);
    check("wdly_wvalid_cycles", wv_cyc - wv0, 4);
    check("wdly_b_count", b_cnt - b0, 1);
    repeat (4) @(posedge clk);
    check("wdly_single_rsp", rsp_q.size(), 0);
    send(1'b0, 1'b0, 5'h8, 32'd0, acc);
    expect_rsp("wdly_readback", 1'b0, 32'h33, 2'b00, acc + 3);

    // Slave error relayed
    bresp_cfg = 2'b10;
    send(1'b1, 1'b1, 5'h4, 32'h55, acc);
    expect_rsp("bresp", 1'b1, 32'd0, 2'b10, acc + 3);
    bresp_cfg = 2'b00;

    // Asynchronous reset while waiting for RVALID
    r_stall = 1'b1;
    send(1'b0, 1'b0, 5'h0, 32'd0, acc);
    for (int i = 0; i < 20 && !bus.RREADY; i++) @(negedge clk);
    check("abort_in_rd_r", 32'(bus.RREADY), 32'd1);
    #1 rst = 1'b1;
    #1 check("abort_async", 32'({bus.ARVALID, bus.RREADY, rsp_valid}), 32'd0);
    @(posedge clk); #1 r_stall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    check("abort_no_rsp", rsp_q.size(), 0);
    send(1'b0, 1'b0, 5'hC, 32'd0, acc);
    expect_rsp("post_reset_rd", 1'b0, 32'd4, 2'b00, acc + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
